// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM channel: FSM state encoding.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Duty-cycle shadow register: valid/ready handshake, saturation on accept,
// and a pending flag that hands the value to the active duty on a wrap.
module pwm_shadow_reg
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cfg_valid_i,
   input  logic [WIDTH:0]   cfg_duty_i,
   input  logic             wrap_i,
   output logic             cfg_ready_o,
   output logic [WIDTH:0]   shadow_o,
   output logic             load_o
);

   localparam logic [WIDTH:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

   logic [WIDTH:0] shadow_q, shadow_d;
   logic           pending_q, pending_d;
   logic           accept;
   logic           load;

   // Accept and load are mutually exclusive: accept needs pending low, load
   // needs it high, so a same-cycle accept only lands at the following wrap.
   always_comb begin
      shadow_d  = shadow_q;
      pending_d = pending_q;
      accept    = cfg_valid_i && !pending_q;
      load      = wrap_i && pending_q;
      if (load) begin
         pending_d = 1'b0;
      end
      if (accept) begin
         shadow_d  = (cfg_duty_i > DUTY_MAX) ? DUTY_MAX : cfg_duty_i;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
      end
   end

   assign cfg_ready_o = !pending_q;
   assign shadow_o    = shadow_q;
   assign load_o      = load;

endmodule

// File: rtl/pwm_channel.sv
// PWM channel slaved to an external wrap-around counter; duty changes and
// start/stop are aligned to counter wrap so every period is complete.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] count_i,
   input  logic             cnt_en_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [WIDTH:0]   cfg_duty_i,
   input  logic             cfg_enable_i,
   output logic             pwm_o,
   output logic             period_o
);

   pwm_state_e     state_q, state_d;
   logic [WIDTH:0] duty_q, duty_d;
   logic           pwm_q, pwm_d;
   logic           period_q, period_d;
   logic           wrap;
   logic           load;
   logic [WIDTH:0] shadow;

   assign wrap = cnt_en_i && (count_i == {WIDTH{1'b1}});

   pwm_shadow_reg #(
      .WIDTH (WIDTH)
   ) u_shadow (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cfg_valid_i (cfg_valid_i),
      .cfg_duty_i  (cfg_duty_i),
      .wrap_i      (wrap),
      .cfg_ready_o (cfg_ready_o),
      .shadow_o    (shadow),
      .load_o      (load)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (cfg_enable_i) state_d = ST_SYNC;
         ST_SYNC: begin
            if (!cfg_enable_i)   state_d = ST_IDLE;
            else if (wrap)       state_d = ST_RUN;
         end
         ST_RUN:  if (wrap && !cfg_enable_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // A frozen count re-evaluates to the same compare result, so pwm holds.
   always_comb begin
      duty_d   = load ? shadow : duty_q;
      pwm_d    = (state_q == ST_RUN) && ({1'b0, count_i} < duty_q);
      period_d = wrap && (state_d == ST_RUN);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         duty_q   <= '0;
         pwm_q    <= 1'b0;
         period_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         pwm_q    <= pwm_d;
         period_q <= period_d;
      end
   end

   assign pwm_o    = pwm_q;
   assign period_o = period_q;

endmodule

// File: doc/pwm_channel.md
PWM_CHANNEL -- requirements
Module: pwm_channel

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the count input; the PWM period is 2^WIDTH counter steps.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 count_i  input  WIDTH  current value of the upstream free-running wrap-around counter.
REQ-005 cnt_en_i  input  1  the same enable that drives the upstream counter; high means count_i advances this cycle.
REQ-006 cfg_valid_i  input  1  a new duty value is offered.
REQ-007 cfg_ready_o  output  1  the block can accept a new duty value.
REQ-008 cfg_duty_i  input  WIDTH+1  requested high-time in counter steps, 0..2^WIDTH.
REQ-009 cfg_enable_i  input  1  level request to run (1) or stop (0) the output.
REQ-010 pwm_o  output  1  registered PWM output.
REQ-011 period_o  output  1  one-cycle pulse marking the start of each running period.

Function
REQ-012 A wrap event SHALL be defined as cnt_en_i=1 and count_i=2^WIDTH-1 in the same cycle.
REQ-013 A duty value SHALL be accepted on a cycle with cfg_valid_i=1 and cfg_ready_o=1.
REQ-014 An accepted value SHALL be stored in a shadow register and set a pending flag.
REQ-015 cfg_ready_o SHALL equal NOT pending; holding cfg_valid_i with ready low SHALL have no effect.
REQ-016 On a wrap event with the pending flag set, the active duty SHALL load the shadow value and pending SHALL clear, so cfg_ready_o rises in the next cycle.
REQ-017 An acceptance in the same cycle as a wrap event SHALL NOT change the active duty at that wrap; the value SHALL apply at the following wrap event.
REQ-018 Shadow values above 2^WIDTH SHALL saturate to 2^WIDTH on acceptance.
REQ-019 The FSM SHALL have three states: IDLE, SYNC and RUN.
REQ-020 IDLE->SYNC SHALL occur when cfg_enable_i=1.
REQ-021 SYNC->RUN SHALL occur on a wrap event, so a period always starts at count 0.
REQ-022 SYNC->IDLE SHALL occur when cfg_enable_i=0.
REQ-023 RUN->IDLE SHALL occur only on a wrap event with cfg_enable_i=0, completing the current period.
REQ-024 In RUN, pwm_o SHALL be registered as (count_i < active duty), giving one cycle of latency relative to count_i; in IDLE and SYNC, pwm_o SHALL be 0.
REQ-025 Active duty 0 SHALL hold pwm_o at 0 for the whole period; active duty 2^WIDTH SHALL hold pwm_o at 1 for the whole period.
REQ-026 period_o SHALL pulse for one cycle in the cycle after any wrap event that leaves the FSM in RUN.
REQ-027 With cnt_en_i=0, count_i is frozen; pwm_o SHALL hold its value and no wrap event SHALL occur.
REQ-028 The configuration handshake SHALL operate in all FSM states.

Reset
REQ-029 On a rising clock edge with rst_i=1, the following SHALL be set: state IDLE, active duty 0, shadow 0, pending 0, pwm_o=0, period_o=0, cfg_ready_o=1.
REQ-030 A reset asserted mid-period SHALL discard any pending value.
REQ-031 After a mid-period reset, the output SHALL restart only through SYNC.

Structure
REQ-032 A shared package pwm_pkg SHALL hold the FSM state enum typedef.
REQ-033 Sub-module pwm_shadow_reg SHALL own the shadow register, the pending flag, saturation and the handshake; the top level SHALL own the FSM and the comparator.

Verification
REQ-034 With WIDTH=8, duty 64, enable high and the counter free-running: after the first wrap, pwm_o is high for 64 cycles and low for 192 cycles, and period_o pulses every 256 cycles.
REQ-035 Duty 0 gives pwm_o constantly 0; duty 256 gives constantly 1; an offered value of 300 saturates and gives constantly 1.
REQ-036 Running at duty 64, offering 192 at count 100: ready drops for the rest of the period, the current period keeps 64 high cycles, the next period has 192 high cycles, and ready returns the cycle after the wrap.
REQ-037 Duty accepted in the wrap cycle: the next period keeps the old duty and the period after uses the new duty.
REQ-038 cfg_enable_i dropped at count 50: pwm_o completes the period and then stays 0.
REQ-039 cnt_en_i low for 10 cycles: pwm_o holds its value.
REQ-040 rst_i high for 1 cycle at count 30 in RUN: the next cycle shows pwm_o=0 and cfg_ready_o=1, and the block re-enters RUN only after SYNC.
